// File: rtl/ramw_pkt_pkg.sv
// ramw_pkg: state codes and byte width for the ramw_pkt serializer.
// RAMW_PKT_CKSUM_EN enables the trailing XOR checksum byte.
package ramw_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] IDLE = 8'h00;
  localparam logic [7:0] PREP = 8'h01;
  localparam logic [7:0] SEND = 8'h10;
  localparam logic [7:0] CSUM = 8'h20;
  localparam logic [7:0] LAST = 8'h80;

  typedef enum logic [7:0] {
    S_IDLE = IDLE,
    S_PREP = PREP,
    S_SEND = SEND,
    S_CSUM = CSUM,
    S_LAST = LAST
  } state_t;

endpackage

// File: rtl/ramw_pkt_if.sv
// ramw_pkt_if: frame source and TX FIFO write port of ramw_pkt.
// master is the surrounding logic, slave is the serializer.
interface ramw_pkt_if #(
  parameter int NBYTE = 12
);
  import ramw_pkg::*;

  logic [BYTE_W*NBYTE-1:0] data;
  logic                    fs;
  logic                    fd;
  logic                    fifoe_full;
  logic                    fifoe_txen;
  logic [BYTE_W-1:0]       fifoe_txd;
  logic [BYTE_W-1:0]       so;

  modport master (
    output data, fs, fifoe_full,
    input  fd, so, fifoe_txen, fifoe_txd
  );

  modport slave (
    input  data, fs, fifoe_full,
    output fd, so, fifoe_txen, fifoe_txd
  );

endinterface

// File: rtl/ramw_pkt_shift.sv
// ramw_pkt_shift: frame capture register with a byte selector.
// Shifts toward the selected end so the current byte sits at a fixed slice.
module ramw_pkt_shift
  import ramw_pkg::*;
#(
  parameter int NBYTE     = 12,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  input  logic [BYTE_W*NBYTE-1:0] data,
  output logic [BYTE_W-1:0]       cur
);

  localparam int W = BYTE_W * NBYTE;

  logic [W-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data;
    end else if (advance) begin
      if (MSB_FIRST)
        sreg <= {sreg[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      else
        sreg <= {{BYTE_W{1'b0}}, sreg[W-1:BYTE_W]};
    end
  end

  assign cur = MSB_FIRST ? sreg[W-1 -: BYTE_W]
                         : sreg[BYTE_W-1:0];

endmodule

// File: rtl/ramw_pkt.sv
// ramw_pkt: stalling byte serializer into the Ethernet TX FIFO.
// Define RAMW_PKT_CKSUM_EN to append an XOR checksum byte per frame.
module ramw_pkt
  import ramw_pkg::*;
#(
  parameter int NBYTE     = 12,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  ramw_pkt_if.slave bus
);

  localparam int CW = $clog2(NBYTE);
  localparam logic [CW-1:0] CNT_END = CW'(NBYTE - 1);

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic              load;
  logic              adv;
  logic              wr;
  logic              last_byte;
  logic              txen;
  logic [BYTE_W-1:0] wr_d;
  logic [BYTE_W-1:0] cur;
  logic [BYTE_W-1:0] txd;
`ifdef RAMW_PKT_CKSUM_EN
  logic [BYTE_W-1:0] acc;
`endif

  ramw_pkt_shift #(
    .NBYTE     (NBYTE),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (adv),
    .data    (bus.data),
    .cur     (cur)
  );

  assign last_byte = (cnt == CNT_END);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    wr       = 1'b0;
    wr_d     = '0;
    case (state)
      S_IDLE: if (!bus.fifoe_full) state_nx = S_PREP;
      S_PREP: if (bus.fs) begin
        state_nx = S_SEND;
        load     = 1'b1;
      end
      S_SEND: if (!bus.fifoe_full) begin
        wr   = 1'b1;
        wr_d = cur;
        adv  = 1'b1;
        if (last_byte)
`ifdef RAMW_PKT_CKSUM_EN
          state_nx = S_CSUM;
`else
          state_nx = S_LAST;
`endif
      end
`ifdef RAMW_PKT_CKSUM_EN
      S_CSUM: if (!bus.fifoe_full) begin
        wr       = 1'b1;
        wr_d     = acc;
        state_nx = S_LAST;
      end
`endif
      S_LAST: if (!bus.fs) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // cnt stops on the last byte so it never wraps mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      txen  <= 1'b0;
      txd   <= '0;
    end else begin
      state <= state_nx;
      txen  <= wr;
      txd   <= wr_d;
      if (load)
        cnt <= '0;
      else if (adv && !last_byte)
        cnt <= cnt + 1'b1;
    end
  end

`ifdef RAMW_PKT_CKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (load)
      acc <= '0;
    else if (adv)
      acc <= acc ^ cur;
  end
`endif

  assign bus.so         = state;
  assign bus.fd         = (state == S_LAST);
  assign bus.fifoe_txen = txen;
  assign bus.fifoe_txd  = txd;

endmodule

// File: doc/ramw_pkt.md
# ramw_pkt

Parametrised byte serializer for the MAC transmit path. It captures an NBYTE-wide parallel word on a frame-start handshake and writes it byte by byte into the Ethernet-side TX FIFO. Unlike the fixed 12-byte writer, it stalls on `fifoe_full` in mid-frame without dropping bytes and has a selectable byte order. It can also append an XOR checksum byte. It sits between the sample/packet assembler (which drives `fs`/`fd`) and the TX FIFO write port.

## Interface
- `NBYTE`, 12: bytes per frame, ≥2.
- `MSB_FIRST`, 1: 1 sends `data[8*NBYTE-1 -: 8]` first; 0 sends `data[7:0]` first.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `data`  in  8*NBYTE  parallel frame word; sampled only at capture.
- `fs`  in  1  frame start request; level, held until `fd` seen.
- `fd`  out  1  frame done; high while in LAST.
- `fifoe_full`  in  1  TX FIFO full; a byte is written only while low.
- `so`  out  8  current state code, for debug.
- `fifoe_txen`  out  1  registered FIFO write enable.
- `fifoe_txd`  out  8  registered FIFO write data.

## Operation
- States and codes:
  - IDLE 8'h00
  - PREP 8'h01
  - SEND 8'h10
  - CSUM 8'h20 (macro only)
  - LAST 8'h80
  - any other code → IDLE
- `so` equals the state register. `fd` is `(state==LAST)`.
- IDLE → PREP when `~fifoe_full`; otherwise stay in IDLE.
- PREP → SEND when `fs`:
  - the same edge loads `data` into the capture register;
  - byte counter `cnt` is cleared to 0;
  - checksum accumulator is cleared to 0.
- SEND, cycle with `~fifoe_full`:
  - emit byte `cnt` in the configured order;
  - `cnt` += 1, accumulator ^= byte;
  - after the byte with `cnt==NBYTE-1`, go to CSUM (macro) or LAST.
- SEND, cycle with `fifoe_full`: no write; `cnt`, capture register and accumulator hold.
- CSUM, cycle with `~fifoe_full`: emit the accumulator, then go to LAST. While full, hold.
- LAST → IDLE when `~fs`; stay in LAST while `fs` is high.
- `data` may change freely after capture. The transmitted frame is always the captured value.
- `cnt` width is `$clog2(NBYTE)`; it never wraps inside a frame.

## Timing
- Reset values (asynchronous, all registers):
  - state IDLE, so 8'h00, fd 0
  - fifoe_txen 0, fifoe_txd 8'h00
  - cnt 0, capture register 0, accumulator 0
- `fifoe_full` is sampled in the same cycle as the write decision. If state is SEND/CSUM at edge t and `~fifoe_full`, then `fifoe_txen`=1 and `fifoe_txd`=byte after edge t+1.
- Any cycle without a write: `fifoe_txen`=0 and `fifoe_txd`=8'h00 on the next edge.
- Frame latency:
  - `fs` high in PREP at edge t → first byte on the FIFO port after t+2;
  - with no stalls, NBYTE (or NBYTE+1) consecutive txen cycles;
  - `fd` rises the cycle after the last write is issued.
- Each stall cycle inserts exactly one gap; no byte is duplicated or skipped.
- `fs` dropping during SEND is ignored; the frame completes.
- Reset mid-frame aborts at once: `fifoe_txen` goes low asynchronously and the partial frame is not resumed.

## Configuration
- `RAMW_PKT_CKSUM_EN`:
  - Defined: CSUM state present; frame is NBYTE+1 bytes, the last byte being the XOR of all data bytes.
  - Undefined: no CSUM state or accumulator logic; frame is NBYTE bytes, and SEND goes straight to LAST.

## Structure
- Shared package `ramw_pkg`:
  - state code localparams (IDLE, PREP, SEND, CSUM, LAST);
  - `BYTE_W`=8.
- One sub-module, `ramw_pkt_shift`:
  - capture register plus byte selector, parametrised by NBYTE and MSB_FIRST;
  - load / advance inputs, 8-bit byte output.
- The FSM, counter, checksum and output registers stay in the top module.

## Test plan
- Order, MSB first: NBYTE=12, MSB_FIRST=1, data=96'h0102…0C, full=0 → 12 consecutive txen cycles carrying 01..0C, then fd=1, so=8'h80.
- Order, LSB first: same data, MSB_FIRST=0 → bytes 0C..01 in order.
- Stall: full=1 for 3 cycles after the 5th byte is issued → exactly a 3-cycle txen gap, then 06..0C; total 12 writes.
- Capture: change data to all 8'hFF one cycle after capture → the original bytes are still sent.
- Checksum: with `RAMW_PKT_CKSUM_EN`, data=96'h0102…0C → 13th byte 8'h0C (XOR of 01..0C), then fd.
- Reset and fs hold:
  - rst pulse during byte 7 → txen=0 and so=8'h00 immediately;
  - after reset, a fresh frame sends from byte 01;
  - fs held high in LAST → remains in LAST with fd=1 until fs drops.
